// File: rtl/cond_status_unit.sv
// Condition-evaluation unit: owns the NZCV status register, counts in-flight flag setters,
// and returns a registered pass/fail per lane. Optional same-cycle write-back bypass via COND_BYPASS_EN.
module cond_status_unit #(
  parameter int LANES  = 2,
  parameter int PEND_W = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 flag_issue,
  output logic                 issue_ready,
  input  logic                 status_we,
  input  logic [3:0]           status_in,
  input  logic [4*LANES-1:0]   cond,
  input  logic [LANES-1:0]     cond_valid,
  output logic                 cond_ready,
  output logic [LANES-1:0]     pass,
  output logic [LANES-1:0]     pass_valid,
  output logic [3:0]           status_q,
  output logic [PEND_W-1:0]    pend_cnt
);

  localparam logic [PEND_W-1:0] PEND_MAX = {PEND_W{1'b1}};
  localparam logic [PEND_W-1:0] PEND_ONE = PEND_W'(1);

  typedef enum logic [3:0] {
    C_EQ = 4'b0000, C_NE = 4'b0001, C_CS = 4'b0010, C_CC = 4'b0011,
    C_MI = 4'b0100, C_PL = 4'b0101, C_VS = 4'b0110, C_VC = 4'b0111,
    C_HI = 4'b1000, C_LS = 4'b1001, C_GE = 4'b1010, C_LT = 4'b1011,
    C_GT = 4'b1100, C_LE = 4'b1101, C_AL = 4'b1110, C_NV = 4'b1111
  } cond_e;

  // Flags are packed {N,Z,C,V}.
  function automatic logic cond_eval(input logic [3:0] code, input logic [3:0] flags);
    logic n, z, c, v;
    logic res;
    n = flags[3];
    z = flags[2];
    c = flags[1];
    v = flags[0];
    res = 1'b0;
    case (cond_e'(code))
      C_EQ: res = z;
      C_NE: res = ~z;
      C_CS: res = c;
      C_CC: res = ~c;
      C_MI: res = n;
      C_PL: res = ~n;
      C_VS: res = v;
      C_VC: res = ~v;
      C_HI: res = c & ~z;
      C_LS: res = ~c | z;
      C_GE: res = (n == v);
      C_LT: res = (n != v);
      C_GT: res = ~z & (n == v);
      C_LE: res = z | (n != v);
      C_AL: res = 1'b1;
      C_NV: res = 1'b0;
      default: res = 1'b0;
    endcase
    return res;
  endfunction

  logic                issue_acc;
  logic                retire;
  logic                bypass_hit;
  logic [3:0]          eval_flags;
  logic [PEND_W-1:0]   pend_next;
  logic [LANES-1:0]    pass_d;
  logic [LANES-1:0]    pass_valid_d;

  assign issue_ready = (pend_cnt != PEND_MAX);
  assign issue_acc   = flag_issue && issue_ready;
  assign retire      = status_we && (pend_cnt != '0);

`ifdef COND_BYPASS_EN
  // The last outstanding setter retiring this cycle may feed its flags straight to the query.
  assign bypass_hit  = status_we && (pend_cnt == PEND_ONE) && !issue_acc;
  assign eval_flags  = bypass_hit ? status_in : status_q;
`else
  assign bypass_hit  = 1'b0;
  assign eval_flags  = status_q;
`endif

  // Queries issued alongside flag_issue are older, so they see the pre-issue count.
  assign cond_ready  = (pend_cnt == '0) || bypass_hit;

  always_comb begin
    pend_next = pend_cnt;
    case ({issue_acc, retire})
      2'b10:   pend_next = pend_cnt + PEND_ONE;
      2'b01:   pend_next = pend_cnt - PEND_ONE;
      default: pend_next = pend_cnt;
    endcase
  end

  always_comb begin
    pass_d       = '0;
    pass_valid_d = '0;
    for (int i = 0; i < LANES; i++) begin
      if (cond_valid[i] && cond_ready) begin
        pass_valid_d[i] = 1'b1;
        pass_d[i]       = cond_eval(cond[4*i +: 4], eval_flags);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      status_q   <= '0;
      pend_cnt   <= '0;
      pass       <= '0;
      pass_valid <= '0;
    end else begin
      if (status_we)
        status_q <= status_in;
      pend_cnt   <= pend_next;
      pass       <= pass_d;
      pass_valid <= pass_valid_d;
    end
  end

endmodule

// File: tb/tb_cond_status_unit.sv
// Directed self-checking bench for cond_status_unit (LANES=2, PEND_W=2); expectations
// follow COND_BYPASS_EN when that macro is defined for the build.
module tb_cond_status_unit;

  localparam int LANES  = 2;
  localparam int PEND_W = 2;

  logic                clk;
  logic                rst;
  logic                flag_issue;
  logic                issue_ready;
  logic                status_we;
  logic [3:0]          status_in;
  logic [4*LANES-1:0]  cond;
  logic [LANES-1:0]    cond_valid;
  logic                cond_ready;
  logic [LANES-1:0]    pass;
  logic [LANES-1:0]    pass_valid;
  logic [3:0]          status_q;
  logic [PEND_W-1:0]   pend_cnt;

  int check_count;
  int error_count;

  cond_status_unit #(.LANES(LANES), .PEND_W(PEND_W)) dut (
    .clk         (clk),
    .rst         (rst),
    .flag_issue  (flag_issue),
    .issue_ready (issue_ready),
    .status_we   (status_we),
    .status_in   (status_in),
    .cond        (cond),
    .cond_valid  (cond_valid),
    .cond_ready  (cond_ready),
    .pass        (pass),
    .pass_valid  (pass_valid),
    .status_q    (status_q),
    .pend_cnt    (pend_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    check_count++;
    if (observed !== expected) begin
      error_count++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, observed, expected, $time);
    end
  endtask

  task automatic applyStimulus(input logic fi, input logic we, input logic [3:0] sin,
                               input logic [7:0] c, input logic [1:0] cv);
    flag_issue = fi;
    status_we  = we;
    status_in  = sin;
    cond       = c;
    cond_valid = cv;
  endtask

  // One rising edge, then sample on the falling edge.
  task automatic stepCycle();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    check_count = 0;
    error_count = 0;
    rst = 1'b1;
    applyStimulus(0, 0, 4'h0, 8'h00, 2'b00);
    repeat (2) @(negedge clk);

    checkOutput("rst_status", status_q, 4'h0);
    checkOutput("rst_pend", pend_cnt, 0);
    checkOutput("rst_pass", pass, 0);
    checkOutput("rst_pvalid", pass_valid, 0);
    checkOutput("rst_issue_ready", issue_ready, 1);
    checkOutput("rst_cond_ready", cond_ready, 1);
    rst = 1'b0;

    // lane1 NV, lane0 AL
    applyStimulus(0, 0, 4'h0, 8'hFE, 2'b11);
    stepCycle();
    checkOutput("al_nv_pass", pass, 2'b01);
    checkOutput("al_nv_pvalid", pass_valid, 2'b11);

    // Z=1,C=1: lane1 HI=0, lane0 LS=1
    applyStimulus(0, 1, 4'b0110, 8'h00, 2'b00);
    stepCycle();
    checkOutput("wb_status", status_q, 4'b0110);
    checkOutput("wb_pend_zero", pend_cnt, 0);
    checkOutput("wb_pvalid_idle", pass_valid, 0);
    applyStimulus(0, 0, 4'h0, 8'h89, 2'b11);
    stepCycle();
    checkOutput("hi_ls_pass", pass, 2'b01);
    checkOutput("hi_ls_pvalid", pass_valid, 2'b11);

    // C only: lane0 LE=0, lane1 idle
    applyStimulus(0, 1, 4'b0010, 8'h00, 2'b00);
    stepCycle();
    applyStimulus(0, 0, 4'h0, 8'h0D, 2'b01);
    stepCycle();
    checkOutput("le_pass", pass, 2'b00);
    checkOutput("le_pvalid", pass_valid, 2'b01);

    // Stall: issue at t, GE query from t+1, write-back of N=1,V=1 at t+3
    applyStimulus(1, 0, 4'h0, 8'h00, 2'b00);
    stepCycle();
    checkOutput("stall_pend1", pend_cnt, 1);
    applyStimulus(0, 0, 4'h0, 8'h0A, 2'b01);
    checkOutput("stall_ready_t1", cond_ready, 0);
    stepCycle();
    checkOutput("stall_pvalid_t2", pass_valid, 0);
    checkOutput("stall_ready_t2", cond_ready, 0);
    stepCycle();
    checkOutput("stall_pvalid_t3", pass_valid, 0);
    applyStimulus(0, 1, 4'b1001, 8'h0A, 2'b01);
`ifdef COND_BYPASS_EN
    checkOutput("bypass_ready_t3", cond_ready, 1);
    stepCycle();
    checkOutput("bypass_pvalid_t4", pass_valid, 2'b01);
    checkOutput("bypass_pass_t4", pass, 2'b01);
    checkOutput("bypass_pend_t4", pend_cnt, 0);
    applyStimulus(0, 0, 4'h0, 8'h00, 2'b00);
    stepCycle();
    checkOutput("bypass_pvalid_t5", pass_valid, 0);
`else
    checkOutput("stall_ready_t3", cond_ready, 0);
    stepCycle();
    checkOutput("stall_pvalid_t4", pass_valid, 0);
    applyStimulus(0, 0, 4'h0, 8'h0A, 2'b01);
    checkOutput("stall_ready_t4", cond_ready, 1);
    checkOutput("stall_status_t4", status_q, 4'b1001);
    stepCycle();
    checkOutput("stall_pvalid_t5", pass_valid, 2'b01);
    checkOutput("stall_pass_t5", pass, 2'b01);
    applyStimulus(0, 0, 4'h0, 8'h00, 2'b00);
    stepCycle();
    checkOutput("stall_pvalid_t6", pass_valid, 0);
`endif

    // Saturation of the scoreboard
    applyStimulus(1, 0, 4'h0, 8'h00, 2'b00);
    stepCycle();
    checkOutput("sat_pend1", pend_cnt, 1);
    stepCycle();
    checkOutput("sat_pend2", pend_cnt, 2);
    checkOutput("sat_ready_at2", issue_ready, 1);
    stepCycle();
    checkOutput("sat_pend3", pend_cnt, 3);
    checkOutput("sat_ready_at3", issue_ready, 0);
    stepCycle();
    checkOutput("sat_pend_hold", pend_cnt, 3);
    applyStimulus(1, 1, 4'h0, 8'h00, 2'b00);
    stepCycle();
    checkOutput("sat_issue_retire", pend_cnt, 2);
    applyStimulus(0, 1, 4'h0, 8'h00, 2'b00);
    stepCycle();
    stepCycle();
    checkOutput("drain_pend0", pend_cnt, 0);

    // Write-back with nothing pending: N=1,Z=1
    applyStimulus(0, 1, 4'b1100, 8'h00, 2'b00);
    stepCycle();
    checkOutput("idle_wb_status", status_q, 4'b1100);
    checkOutput("idle_wb_pend", pend_cnt, 0);

    // lane1 GT=0, lane0 MI=1; then lane1 LT=1, lane0 EQ=1
    applyStimulus(0, 0, 4'h0, 8'hC4, 2'b11);
    stepCycle();
    checkOutput("gt_mi_pass", pass, 2'b01);
    applyStimulus(0, 0, 4'h0, 8'hB0, 2'b11);
    stepCycle();
    checkOutput("lt_eq_pass", pass, 2'b11);
    checkOutput("lt_eq_pvalid", pass_valid, 2'b11);

    applyStimulus(1, 0, 4'h0, 8'h00, 2'b00);
    stepCycle();
    checkOutput("swap_pend1", pend_cnt, 1);
    applyStimulus(1, 1, 4'b1100, 8'h00, 2'b00);
    stepCycle();
    checkOutput("swap_pend_same", pend_cnt, 1);
    applyStimulus(1, 0, 4'h0, 8'h00, 2'b00);
    stepCycle();
    checkOutput("pre_rst_pend2", pend_cnt, 2);

    // Asynchronous reset with a blocked query and two setters in flight
    applyStimulus(0, 0, 4'h0, 8'hEE, 2'b11);
    checkOutput("pre_rst_ready", cond_ready, 0);
    #2 rst = 1'b1;
    #1;
    checkOutput("arst_pend", pend_cnt, 0);
    checkOutput("arst_status", status_q, 4'h0);
    checkOutput("arst_pvalid", pass_valid, 0);
    checkOutput("arst_issue_ready", issue_ready, 1);
    @(negedge clk);
    applyStimulus(0, 0, 4'h0, 8'h00, 2'b00);
    rst = 1'b0;
    stepCycle();
    checkOutput("arst_no_pulse", pass_valid, 0);

    // Reset landing on an in-flight result drops the pulse
    applyStimulus(0, 0, 4'h0, 8'h0E, 2'b01);
    @(posedge clk);
    #1;
    checkOutput("inflight_pvalid", pass_valid, 2'b01);
    applyStimulus(0, 0, 4'h0, 8'h00, 2'b00);
    #1 rst = 1'b1;
    #1;
    checkOutput("inflight_drop_pvalid", pass_valid, 0);
    checkOutput("inflight_drop_pass", pass, 0);
    @(negedge clk);
    rst = 1'b0;
    stepCycle();
    checkOutput("inflight_no_late", pass_valid, 0);

    $display("Simulation finished: %0d checks, %0d errors", check_count, error_count);
    $finish;
  end

endmodule
